// File: rtl/fir_channel_scheduler_if.sv
// -----------------------------------------------------------------------------
// fir_channel_scheduler_if
// Bundles every non-clock, non-reset signal of the FIR channel scheduler.
// The scheduler uses the slave modport. The channel sources, the coefficient
// writer and the shared FIR datapath sit on the master side.
//
// Signals (direction seen from the scheduler / slave):
//   i_valid      in   N_CH              per-channel sample valid
//   i_data       in   N_CH*NB_IN        channel c sample at [(c+1)*NB_IN-1 -: NB_IN]
//   o_ready      out  N_CH              one-hot grant
//   i_clear      in   1                 zero histories, drop in-flight sample
//   i_coef_we    in   1                 coefficient write strobe
//   i_coef_addr  in   $clog2(N_COEFFS)  tap index to write
//   i_coef_data  in   NB_COEFFS         signed coefficient
//   o_fir_data   out  NB_IN*N_COEFFS    registered tap window to the FIR
//   o_fir_coeffs out  NB_COEFFS x N_COEFFS coefficient bank to the FIR
//   i_fir_data   in   NB_OUT            combinational FIR sum
//   o_valid      out  1                 result strobe
//   o_ch         out  $clog2(N_CH)      channel of o_data
//   o_data       out  NB_OUT            signed result
//   o_sat        out  1                 result was clamped
// -----------------------------------------------------------------------------
interface fir_channel_scheduler_if #(
  parameter int NB_IN     = 8,
  parameter int NB_COEFFS = 8,
  parameter int N_COEFFS  = 8,
  parameter int N_CH      = 4,
  parameter int NB_OUT    = NB_IN + NB_COEFFS + $clog2(N_COEFFS)
);

  logic [N_CH-1:0]               i_valid;
  logic [N_CH*NB_IN-1:0]         i_data;
  logic [N_CH-1:0]               o_ready;
  logic                          i_clear;
  logic                          i_coef_we;
  logic [$clog2(N_COEFFS)-1:0]   i_coef_addr;
  logic signed [NB_COEFFS-1:0]   i_coef_data;
  logic [NB_IN*N_COEFFS-1:0]     o_fir_data;
  logic signed [NB_COEFFS-1:0]   o_fir_coeffs [N_COEFFS];
  logic signed [NB_OUT-1:0]      i_fir_data;
  logic                          o_valid;
  logic [$clog2(N_CH)-1:0]       o_ch;
  logic signed [NB_OUT-1:0]      o_data;
  logic                          o_sat;

  // Sources, coefficient writer and FIR datapath side.
  modport master (
    output i_valid, i_data, i_clear, i_coef_we, i_coef_addr, i_coef_data, i_fir_data,
    input  o_ready, o_fir_data, o_fir_coeffs, o_valid, o_ch, o_data, o_sat
  );

  // Scheduler side.
  modport slave (
    input  i_valid, i_data, i_clear, i_coef_we, i_coef_addr, i_coef_data, i_fir_data,
    output o_ready, o_fir_data, o_fir_coeffs, o_valid, o_ch, o_data, o_sat
  );

endinterface

// File: rtl/fir_channel_scheduler.sv
// -----------------------------------------------------------------------------
// fir_channel_scheduler
// Time-shares one combinational parallel FIR across N_CH channels. Each channel
// owns an N_COEFFS-deep sample history; the coefficient bank is shared and
// writable at run time. A round-robin arbiter accepts one sample per cycle,
// shifts it into that channel's history and registers the updated tap window
// towards the FIR (stage 0). The next edge captures the FIR sum together with
// the channel id (stage 1).
//
// Ports:
//   i_clock  in   rising-edge clock
//   i_reset  in   synchronous, active-high reset (overrides clear and writes)
//   bus      slave modport of fir_channel_scheduler_if (handshake, coefficient
//            write port, FIR window/coefficient/sum, tagged result)
//
// Optional feature macro: FIR_SCHED_SAT_EN
//   defined   -> stage 1 clamps the FIR sum to NB_SAT signed bits
//                (sign-extended to NB_OUT) and flags o_sat
//   undefined -> the FIR sum passes through unmodified, o_sat stays 0
// -----------------------------------------------------------------------------
module fir_channel_scheduler #(
  parameter int NB_IN     = 8,
  parameter int NB_COEFFS = 8,
  parameter int N_COEFFS  = 8,
  parameter int N_CH      = 4,
  parameter int NB_OUT    = NB_IN + NB_COEFFS + $clog2(N_COEFFS),
  parameter int NB_SAT    = 12
) (
  input  logic                   i_clock,
  input  logic                   i_reset,
  fir_channel_scheduler_if.slave bus
);

  localparam int CH_W  = $clog2(N_CH);
  localparam int WIN_W = NB_IN * N_COEFFS;

  localparam logic [N_CH-1:0] ONE_HOT_C = {{(N_CH-1){1'b0}}, 1'b1};

  // ---------------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------------

  // (base + offset) modulo N_CH; offset is always below N_CH.
  function automatic logic [CH_W-1:0] wrap_inc(input logic [CH_W-1:0] base, input int offset);
    int sum;
    sum = int'(base) + offset;
    sum = (sum >= N_CH) ? (sum - N_CH) : sum;
    return CH_W'(sum);
  endfunction

  // Clamp to the NB_SAT signed range. The MSB of the result is the clamp flag,
  // the lower NB_OUT bits are the sign-extended clamped value.
  function automatic logic [NB_OUT:0] sat_clamp(input logic signed [NB_OUT-1:0] value);
    logic signed [NB_OUT-1:0] hi;
    logic signed [NB_OUT-1:0] lo;
    hi = {{(NB_OUT-NB_SAT+1){1'b0}}, {(NB_SAT-1){1'b1}}};
    lo = {{(NB_OUT-NB_SAT+1){1'b1}}, {(NB_SAT-1){1'b0}}};
    if (value > hi) begin
      return {1'b1, hi};
    end else if (value < lo) begin
      return {1'b1, lo};
    end else begin
      return {1'b0, value};
    end
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [CH_W-1:0]             ptr_r;
  logic [NB_IN-1:0]            hist_r [N_CH][N_COEFFS];
  logic signed [NB_COEFFS-1:0] coef_r [N_COEFFS];
  logic [WIN_W-1:0]            fir_data_r;
  logic                        vld_r;
  logic [CH_W-1:0]             ch_r;
  logic                        o_valid_r;
  logic [CH_W-1:0]             o_ch_r;
  logic [NB_OUT-1:0]           o_data_r;
  logic                        o_sat_r;

  logic                        found_s;
  logic [CH_W-1:0]             grant_idx_s;
  logic                        grant_any_s;
  logic [WIN_W-1:0]            new_win_s;
  logic [NB_OUT:0]             sat_pack_s;

  // ---------------------------------------------------------------------------
  // Round-robin arbiter
  // ---------------------------------------------------------------------------

  // Pick the first requester at or after the pointer, wrapping at N_CH.
  always_comb begin
    found_s     = 1'b0;
    grant_idx_s = {CH_W{1'b0}};
    for (int k = 0; k < N_CH; k++) begin
      grant_idx_s = (!found_s && bus.i_valid[wrap_inc(ptr_r, k)]) ? wrap_inc(ptr_r, k) : grant_idx_s;
      found_s     = found_s | bus.i_valid[wrap_inc(ptr_r, k)];
    end
  end

  // Reset and clear both block acceptance, so o_ready is never raised then.
  assign grant_any_s = found_s & ~i_reset & ~bus.i_clear;
  assign bus.o_ready = grant_any_s ? (ONE_HOT_C << grant_idx_s) : {N_CH{1'b0}};

  // ---------------------------------------------------------------------------
  // Stage 0: history update and tap window
  // ---------------------------------------------------------------------------

  // Window of the granted channel after the new sample has shifted into tap 0.
  always_comb begin
    new_win_s              = {WIN_W{1'b0}};
    new_win_s[NB_IN-1:0]   = bus.i_data[grant_idx_s*NB_IN +: NB_IN];
    for (int j = 1; j < N_COEFFS; j++) begin
      new_win_s[j*NB_IN +: NB_IN] = hist_r[grant_idx_s][j-1];
    end
  end

  // Histories, registered FIR window, pointer and the stage-0 valid/channel tag.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      for (int c = 0; c < N_CH; c++) begin
        for (int j = 0; j < N_COEFFS; j++) begin
          hist_r[c][j] <= {NB_IN{1'b0}};
        end
      end
      fir_data_r <= {WIN_W{1'b0}};
      vld_r      <= 1'b0;
      ch_r       <= {CH_W{1'b0}};
      ptr_r      <= {CH_W{1'b0}};
    end else if (bus.i_clear) begin
      // Pointer and coefficients survive a clear; only sample state is dropped.
      for (int c = 0; c < N_CH; c++) begin
        for (int j = 0; j < N_COEFFS; j++) begin
          hist_r[c][j] <= {NB_IN{1'b0}};
        end
      end
      fir_data_r <= {WIN_W{1'b0}};
      vld_r      <= 1'b0;
    end else if (grant_any_s) begin
      for (int j = 0; j < N_COEFFS; j++) begin
        hist_r[grant_idx_s][j] <= new_win_s[j*NB_IN +: NB_IN];
      end
      fir_data_r <= new_win_s;
      vld_r      <= 1'b1;
      ch_r       <= grant_idx_s;
      ptr_r      <= wrap_inc(grant_idx_s, 1);
    end else begin
      vld_r      <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Coefficient bank
  // ---------------------------------------------------------------------------

  // Shared coefficients; writes to addresses beyond the bank are dropped.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      for (int j = 0; j < N_COEFFS; j++) begin
        coef_r[j] <= {NB_COEFFS{1'b0}};
      end
    end else if (bus.i_coef_we && (int'(bus.i_coef_addr) < N_COEFFS)) begin
      coef_r[bus.i_coef_addr] <= bus.i_coef_data;
    end else begin
      for (int j = 0; j < N_COEFFS; j++) begin
        coef_r[j] <= coef_r[j];
      end
    end
  end

  // The bank drives the FIR directly, so a write is seen by the very next sum.
  for (genvar j = 0; j < N_COEFFS; j++) begin : g_coef_out
    assign bus.o_fir_coeffs[j] = coef_r[j];
  end

  assign bus.o_fir_data = fir_data_r;

  // ---------------------------------------------------------------------------
  // Stage 1: result capture
  // ---------------------------------------------------------------------------

`ifdef FIR_SCHED_SAT_EN
  assign sat_pack_s = sat_clamp(bus.i_fir_data);
`else
  assign sat_pack_s = {1'b0, bus.i_fir_data};
`endif

  // Capture the FIR sum for the sample registered in stage 0. A clear does not
  // touch this stage, so a result already here still completes.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      o_valid_r <= 1'b0;
      o_ch_r    <= {CH_W{1'b0}};
      o_data_r  <= {NB_OUT{1'b0}};
      o_sat_r   <= 1'b0;
    end else if (vld_r) begin
      o_valid_r <= 1'b1;
      o_ch_r    <= ch_r;
      o_data_r  <= sat_pack_s[NB_OUT-1:0];
      o_sat_r   <= sat_pack_s[NB_OUT];
    end else begin
      o_valid_r <= 1'b0;
    end
  end

  assign bus.o_valid = o_valid_r;
  assign bus.o_ch    = o_ch_r;
  assign bus.o_data  = o_data_r;
  assign bus.o_sat   = o_sat_r;

endmodule
